// File: rtl/axiline_sample_feeder.sv
// axiline_sample_feeder: ping-pong sample buffer feeding the Axiline SGD
// datapath. The host streams SIZE feature words and then one label word into
// the free bank. The other bank is sent element-by-element on a valid/ready
// stream that carries x, y and last.
// Optional feature: define AXILINE_FEEDER_CNT_EN to add the sample_cnt port
// and its wrapping 16-bit counter of transmitted samples.

// One storage bank: SIZE feature registers, a label register and a full flag.
module axiline_feeder_bank #(
  parameter int W    = 8,
  parameter int SIZE = 16,
  parameter int IW   = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_x,
  input  logic                     wr_label,
  input  logic [IW-1:0]            wr_idx,
  input  logic [W-1:0]             wr_data,
  input  logic                     clr,
  output logic [SIZE-1:0][W-1:0]   x,
  output logic [W-1:0]             label,
  output logic                     full
);
  // Capture features and the label. The label write marks the bank full.
  // Set and clear never coincide on one bank because the write side only
  // fills a bank that is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      label <= '0;
      full  <= 1'b0;
    end else begin
      if (wr_x) x[wr_idx] <= wr_data;
      if (wr_label) begin
        label <= wr_data;
        full  <= 1'b1;
      end else if (clr) begin
        full  <= 1'b0;
      end
    end
  end
endmodule

module axiline_sample_feeder #(
  parameter int INPUT_BITWIDTH = 8,
  parameter int SIZE           = 16,
  localparam int W             = INPUT_BITWIDTH,
  localparam int IW            = $clog2(SIZE),
  localparam int WIW           = $clog2(SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_x,
  output logic [W-1:0]  m_y,
  output logic          m_last,
  output logic [IW-1:0] m_idx
`ifdef AXILINE_FEEDER_CNT_EN
  ,output logic [15:0]  sample_cnt
`endif
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state;
  logic                         wb, rb;
  logic [WIW-1:0]               widx;
  logic [IW-1:0]                ridx;
  logic [1:0][SIZE-1:0][W-1:0]  bx;
  logic [1:0][W-1:0]            blabel;
  logic [1:0]                   bfull;

  logic s_hs, is_label, lbl_wr, r_hs, r_final;

  assign s_ready  = !bfull[wb];
  assign s_hs     = s_valid && s_ready;
  assign is_label = (widx == WIW'(SIZE));
  assign lbl_wr   = s_hs && is_label;
  assign r_hs     = m_valid && m_ready;
  assign r_final  = r_hs && (ridx == IW'(SIZE - 1));

  // The read side reads only banks whose full flag is set, so these
  // outputs are stable while a stalled element waits for m_ready.
  assign m_x    = bx[rb][ridx];
  assign m_y    = blabel[rb];
  assign m_idx  = ridx;
  assign m_last = m_valid && (ridx == IW'(SIZE - 1));

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      axiline_feeder_bank #(.W(W), .SIZE(SIZE), .IW(IW)) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_x     (s_hs && !is_label && (wb == 1'(b))),
        .wr_label (lbl_wr && (wb == 1'(b))),
        .wr_idx   (widx[IW-1:0]),
        .wr_data  (s_data),
        .clr      (r_final && (rb == 1'(b))),
        .x        (bx[b]),
        .label    (blabel[b]),
        .full     (bfull[b])
      );
    end
  endgenerate

  // Write pointer: step through features, then the label closes the bank
  // and moves to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb   <= 1'b0;
      widx <= '0;
    end else if (s_hs) begin
      if (is_label) begin
        wb   <= ~wb;
        widx <= '0;
      end else begin
        widx <= widx + 1'b1;
      end
    end
  end

  // Read FSM. A label landing in the bank about to be read counts as full
  // already, so the first element is valid the cycle after the label edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      rb      <= 1'b0;
      ridx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bfull[rb] || (lbl_wr && (wb == rb))) begin
            state   <= SEND;
            m_valid <= 1'b1;
          end
        end
        SEND: begin
          if (r_final) begin
            rb   <= ~rb;
            ridx <= '0;
            // Other bank already loaded: continue with no bubble.
            if (!(bfull[~rb] || (lbl_wr && (wb != rb)))) begin
              state   <= IDLE;
              m_valid <= 1'b0;
            end
          end else if (r_hs) begin
            ridx <= ridx + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXILINE_FEEDER_CNT_EN
  // Count completed samples; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sample_cnt <= '0;
    else if (r_final) sample_cnt <= sample_cnt + 16'd1;
  end
`else
  // Sample counter not built.
`endif

endmodule

// File: tb/tb_axiline_sample_feeder.sv
// Scoreboard bench for axiline_sample_feeder (SIZE=4, 8-bit words).
module tb_axiline_sample_feeder;
  localparam int W = 8;
  localparam int SIZE = 4;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   idx;
    logic         last;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready, m_valid, m_last;
  logic [W-1:0] m_x, m_y;
  logic [1:0] m_idx;
`ifdef AXILINE_FEEDER_CNT_EN
  logic [15:0] sample_cnt;
`endif

  int n_chk = 0, n_err = 0;
  exp_t q[$];
  logic [W-1:0] pend[SIZE];
  int tb_widx = 0;

  axiline_sample_feeder #(.INPUT_BITWIDTH(W), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_x(m_x), .m_y(m_y), .m_last(m_last), .m_idx(m_idx)
`ifdef AXILINE_FEEDER_CNT_EN
    ,.sample_cnt(sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; stalls must show the head entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid) begin
        if (q.size() == 0) begin
          if (m_ready) chk("unexp_elem", 32'd1, 32'd0);
        end else if (m_ready) begin
          e = q.pop_front();
          chk("m_x", m_x, e.x);
          chk("m_y", m_y, e.y);
          chk("m_idx", m_idx, e.idx);
          chk("m_last", m_last, e.last);
        end else begin
          chk("hold_x", m_x, q[0].x);
          chk("hold_y", m_y, q[0].y);
          chk("hold_idx", m_idx, q[0].idx);
        end
      end
    end
  end

  // One host beat; returns #1 after the accepting edge (or on timeout).
  task automatic beat(input logic [W-1:0] d);
    bit ok = 0;
    s_valid = 1'b1;
    s_data = d;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) begin
      chk("beat_timeout", 32'd0, 32'd1);
      return;
    end
    if (tb_widx < SIZE) begin
      pend[tb_widx] = d;
      tb_widx++;
    end else begin
      for (int i = 0; i < SIZE; i++)
        q.push_back('{x: pend[i], y: d, idx: 2'(i), last: (i == SIZE - 1)});
      tb_widx = 0;
    end
  endtask

  task automatic send_sample(input logic [W-1:0] x0, input logic [W-1:0] y);
    for (int i = 0; i < SIZE; i++) beat(x0 + W'(i));
    beat(y);
  endtask

  task automatic wait_drain();
    int c = 0;
    while (q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    tb_widx = 0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_x", m_x, 0);
    chk("rst_m_y", m_y, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_idx", m_idx, 0);
`ifdef AXILINE_FEEDER_CNT_EN
    chk("rst_cnt", sample_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // T1: single sample, latency and contiguous stream.
    m_ready = 1'b1;
    send_sample(8'd1, 8'd9);
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      chk("t1_valid", m_valid, 1);
    end
    wait_drain();
    @(negedge clk);
    chk("t1_idle", m_valid, 0);

    // T2: two samples with m_ready low fill both banks.
    @(posedge clk); #1;
    m_ready = 1'b0;
    send_sample(8'd10, 8'd1);
    send_sample(8'd20, 8'd2);
    @(negedge clk);
    chk("t2_s_ready_low", s_ready, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 2 * SIZE; i++) begin
      @(negedge clk);
      chk("t2_nobubble", m_valid, 1);
      if (i == SIZE - 1) chk("t2_y1", m_y, 1);
      if (i == SIZE) chk("t2_y2", m_y, 2);
    end
    wait_drain();

    // T3: stall at ridx=2 for 3 cycles.
    m_ready = 1'b0;
    send_sample(8'd5, 8'd3);
    m_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_valid", m_valid, 1);
      chk("t3_idx", m_idx, 2);
      chk("t3_x", m_x, 7);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain();

    // T4: partial sample stays invisible until its label arrives.
    for (int i = 0; i < SIZE - 1; i++) beat(8'h30 + W'(i));
    repeat (10) begin
      @(negedge clk);
      chk("t4_no_valid", m_valid, 0);
    end
    @(posedge clk); #1;
    beat(8'h33);
    beat(8'h44);
    wait_drain();

    // T5: reset while bank 0 sends (ridx=1) and bank 1 is half written.
    do_reset();
    m_ready = 1'b0;
    send_sample(8'h50, 8'h55);
    beat(8'h60);
    beat(8'h61);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("t5_ridx1", m_idx, 1);
    do_reset();
    m_ready = 1'b1;
    send_sample(8'h70, 8'h77);
    wait_drain();
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_stale", m_valid, 0);
    end

`ifdef AXILINE_FEEDER_CNT_EN
    // Counter: three samples, then wrap from 0xFFFF.
    do_reset();
    m_ready = 1'b1;
    for (int s = 0; s < 3; s++) send_sample(8'h80 + W'(8 * s), W'(s));
    wait_drain();
    @(negedge clk);
    chk("cnt_3", sample_cnt, 3);
    force dut.sample_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.sample_cnt;
    send_sample(8'h90, 8'h99);
    wait_drain();
    @(negedge clk);
    chk("cnt_wrap", sample_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axiline_sample_feeder.md
# axiline_sample_feeder

Ping-pong sample buffer that sources training data into the Axiline SGD datapath. A host writer streams each sample as SIZE feature words followed by one label word. The feeder transmits the buffered sample element-by-element on a valid/ready stream carrying the x element, the sample label y and a last flag. That stream drives the inner-product and gradient stages. Two banks let the host fill one sample while the other is being transmitted.

## Interface
- INPUT_BITWIDTH, 8, width of feature and label words
- SIZE, 16, feature elements per sample (>= 2)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- s_valid  input  1  host beat valid
- s_ready  output  1  feeder can accept a host beat
- s_data  input  INPUT_BITWIDTH  feature word (beats 0..SIZE-1) or label word (beat SIZE)
- m_valid  output  1  element available to datapath
- m_ready  input  1  datapath accepts element
- m_x  output  INPUT_BITWIDTH  current feature element
- m_y  output  INPUT_BITWIDTH  label of sample being transmitted, constant for the whole sample
- m_last  output  1  high with element SIZE-1
- m_idx  output  clog2(SIZE)  index of current element
- sample_cnt  output  16  completed transmitted samples (only with AXILINE_FEEDER_CNT_EN)

## Operation
- Storage: two banks, each with SIZE x registers and one label register, plus flags full[0..1].
- Write pointers: wb (bank), widx (0..SIZE). Read pointers: rb (bank), ridx (0..SIZE-1).
- s_ready = !full[wb]. A host beat is accepted when s_valid && s_ready.
  - widx < SIZE: x[wb][widx] <= s_data; widx++.
  - widx == SIZE: label[wb] <= s_data; full[wb] <= 1; wb toggles; widx <= 0.
- Read side is a 2-state FSM:
  - IDLE: m_valid = 0. Go to SEND when full[rb].
  - SEND: m_valid = 1; m_x = x[rb][ridx]; m_y = label[rb]; m_idx = ridx; m_last = (ridx == SIZE-1).
  - On handshake in SEND with ridx < SIZE-1: ridx++.
  - On handshake in SEND with ridx == SIZE-1: full[rb] <= 0; rb toggles; ridx <= 0.
    - If the other bank is already full (checked as its pre-clear value), stay in SEND so back-to-back samples have no bubble.
    - Otherwise go to IDLE.
- Set and clear of full flags always target different banks; both take effect in the same cycle if they coincide.
- A sample is never transmitted until its label beat has been accepted. Partially written banks are invisible to the read side.
- m_x/m_y/m_idx/m_last must be held stable while m_valid && !m_ready.
- Samples leave in the order they were written, alternating bank 0, 1, 0, ...

## Timing
- Reset values: s_ready = 1, m_valid = 0, m_x = 0, m_y = 0, m_last = 0, m_idx = 0, sample_cnt = 0. All flags and pointers are 0 and the FSM is in IDLE.
- Latency: label beat accepted at edge N -> m_valid high in cycle N+1 with element 0.
- Throughput: 1 element per cycle while m_ready is held high. Host sustains 1 beat per cycle while a bank is free.
- Backpressure: host stalls, with s_ready low, when both banks are full. s_ready rises the cycle after the final element handshake of the bank at wb.
- Reset mid-operation discards all buffered and partial samples. No beat is replayed after reset.

## Configuration
- AXILINE_FEEDER_CNT_EN
  - Defined: sample_cnt port exists. It increments by 1 on each final-element handshake and wraps 0xFFFF -> 0x0000.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- SIZE=4: write 1,2,3,4 then label 9, m_ready=1 -> cycle after label, m_x = 1,2,3,4 on consecutive cycles, m_y=9 throughout, m_last only on x=4, m_idx 0..3.
- Write two samples back-to-back (x=10..13/y=1, x=20..23/y=2) with m_ready=0 -> s_ready drops after the 10th beat. Raising m_ready then gives 8 contiguous elements with no bubble, and y switches 1->2 at element 4.
- Hold m_ready low 3 cycles mid-sample at ridx=2 -> m_x/m_idx/m_y stay stable; ridx advances only after m_ready rises.
- Host writes only 3 of 4 features, then idles -> m_valid stays 0 indefinitely. The next 2 beats (feature plus label) complete the sample and it is transmitted.
- Assert rst_n low while bank 0 is transmitting (at ridx=1) and bank 1 is half written -> all outputs at reset values. A fresh sample written after release is the first one transmitted, starting from bank 0.
- With AXILINE_FEEDER_CNT_EN: transmit 3 samples -> sample_cnt = 3. Preload the counter to 0xFFFF by forcing it, complete one sample -> sample_cnt = 0.
